// File: rtl/ps2_defs.sv
// Shared PS/2 definitions: FSM state codes,
// command bytes and the frame parity helper.
package ps2_defs;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_INHIBIT = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_ACK = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK = 8'hFA;

  // Odd parity: data bits plus parity bit
  // always hold an odd number of ones.
  function automatic logic odd_parity(
    input logic [7:0] d
  );
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// 2-FF synchroniser for a raw PS/2 line plus a
// one-cycle falling-edge pulse; ports: clk, reset_n, din -> sync, fall.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic sync,
  output logic fall
);

  logic [2:0] sh_q;
  logic [2:0] sh_d;

  always_comb sh_d = {sh_q[1:0], din};

  // Lines idle high, so reset to 1 to avoid
  // a false fall right after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sh_q <= 3'b111;
    else          sh_q <= sh_d;
  end

  assign sync = sh_q[1];
  assign fall = sh_q[2] & ~sh_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with inhibit, RTS, frame, ACK.
// Ports: tx_* request/status, ps2*_in raw lines, ps2*_drv pull-low enables.
module ps2_host_tx
  import ps2_defs::*;
#(
  parameter int INHIBIT_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2clk_in,
  input  logic       ps2dat_in,
  output logic       ps2clk_drv,
  output logic       ps2dat_drv
);

  localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                        INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  // Start bit goes out one cycle before the
  // clock release, so clk is low INHIBIT_CYCLES.
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic          clk_s;
  logic          clk_fall;
  logic          dat_s;
  logic          unused_dat_fall;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [9:0]    sreg_q, sreg_d;
  logic          clk_drv_q, clk_drv_d;
  logic          dat_drv_q, dat_drv_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          tmo;

  ps2_sync_edge u_clk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (ps2clk_in),
    .sync    (clk_s),
    .fall    (clk_fall)
  );

  ps2_sync_edge u_dat_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (ps2dat_in),
    .sync    (dat_s),
    .fall    (unused_dat_fall)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
  assign tmo     = (cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitcnt_d  = bitcnt_q;
    sreg_d    = sreg_q;
    clk_drv_d = clk_drv_q;
    dat_drv_d = dat_drv_q;
    done_d    = 1'b0;
    err_d     = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          sreg_d    = {1'b1, odd_parity(tx_data), tx_data};
          err_d     = 1'b0;
          cnt_d     = '0;
          clk_drv_d = 1'b1;
          dat_drv_d = 1'b0;
          state_d   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (dat_drv_q) begin
          clk_drv_d = 1'b0;
          cnt_d     = '0;
          bitcnt_d  = '0;
          state_d   = ST_SHIFT;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q == INH_LAST) dat_drv_d = 1'b1;
        end
      end
      ST_SHIFT, ST_ACK, ST_WAIT: begin
        cnt_d = cnt_inc;
        // Timeout beats a simultaneous clock fall.
        if (tmo) begin
          clk_drv_d = 1'b0;
          dat_drv_d = 1'b0;
          err_d     = 1'b1;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else if (state_q == ST_SHIFT) begin
          if (clk_fall) begin
            dat_drv_d = ~sreg_q[0];
            sreg_d    = {1'b0, sreg_q[9:1]};
            bitcnt_d  = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd9) state_d = ST_ACK;
          end
        end else if (state_q == ST_ACK) begin
          if (clk_fall) begin
            err_d   = dat_s;
            state_d = ST_WAIT;
          end
        end else if (clk_s & dat_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        clk_drv_d = 1'b0;
        dat_drv_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      sreg_q    <= '0;
      clk_drv_q <= 1'b0;
      dat_drv_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      sreg_q    <= sreg_d;
      clk_drv_q <= clk_drv_d;
      dat_drv_q <= dat_drv_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign tx_ready   = (state_q == ST_IDLE);
  assign tx_busy    = ~tx_ready;
  assign tx_done    = done_q;
  assign tx_error   = err_q;
  assign ps2clk_drv = clk_drv_q;
  assign ps2dat_drv = dat_drv_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an
// open-collector keyboard bus model.
module tb_ps2_host_tx;
  import ps2_defs::*;

  localparam int INH = 20;
  localparam int TMO = 600;
  localparam int H = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  logic       ps2clk_in, ps2dat_in;
  logic       ps2clk_drv, ps2dat_drv;
  logic       dev_clk_lo = 1'b0;
  logic       dev_dat_lo = 1'b0;

  assign ps2clk_in = ~(ps2clk_drv | dev_clk_lo);
  assign ps2dat_in = ~(ps2dat_drv | dev_dat_lo);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2clk_in  (ps2clk_in),
    .ps2dat_in  (ps2dat_in),
    .ps2clk_drv (ps2clk_drv),
    .ps2dat_drv (ps2dat_drv)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  logic done_seen = 1'b0;
  logic err_seen = 1'b0;
  int   busy_gaps = 0;
  logic [9:0] bits;
  int   n;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (tx_done) begin
      done_seen = 1'b1;
      err_seen  = tx_error;
    end
    if (!tx_busy && !done_seen) busy_gaps++;
  endtask

  task automatic accept(input logic [7:0] d);
    @(negedge clk);
    tx_data   = d;
    tx_valid  = 1'b1;
    done_seen = 1'b0;
    busy_gaps = 0;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic inhibit(input string tag);
    int len;
    len = 1;
    check({tag, "_clk_lat"}, ps2clk_drv, 1);
    for (int i = 0; i < INH + 10; i++) begin
      tick();
      if (!ps2clk_drv) break;
      len++;
    end
    check({tag, "_inh_len"}, len, INH);
    check({tag, "_start"}, ps2dat_drv, 1);
  endtask

  task automatic device(input logic ack,
                        input int abort_at,
                        output logic [9:0] b);
    b = '0;
    repeat (H) tick();
    for (int k = 1; k <= 11; k++) begin
      dev_clk_lo = 1'b1;
      if (k == abort_at) return;
      repeat (H) tick();
      if (k <= 10) b[k-1] = ps2dat_in;
      dev_clk_lo = 1'b0;
      if (k == 10) begin
        repeat (H / 2) tick();
        dev_dat_lo = ack;
        repeat (H / 2) tick();
      end else begin
        repeat (H) tick();
      end
    end
    dev_dat_lo = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && !done_seen; i++) tick();
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", tx_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_err", tx_error, 0);
    check("rst_clkdrv", ps2clk_drv, 0);
    check("rst_datdrv", ps2dat_drv, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) tick();

    // 0xED with ACK
    accept(CMD_SET_LED);
    inhibit("ed");
    device(1'b1, 0, bits);
    wait_done();
    check("ed_frame", bits, 10'h3ED);
    check("ed_done", done_seen, 1);
    check("ed_err", err_seen, 0);
    check("ed_busy", busy_gaps, 0);
    tick();
    check("ed_ready", tx_ready, 1);

    // 0xF4 with a request poked while busy
    accept(CMD_ENABLE);
    inhibit("f4");
    @(negedge clk);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    device(1'b1, 0, bits);
    wait_done();
    check("f4_frame", bits, 10'h2F4);
    check("f4_parity", bits[8], 0);
    check("f4_done", done_seen, 1);
    check("f4_err", err_seen, 0);
    check("f4_busy", busy_gaps, 0);
    repeat (30) tick();
    check("f4_noqueue_clk", ps2clk_drv, 0);
    check("f4_noqueue_rdy", tx_ready, 1);

    // 0xFF, device withholds ACK
    accept(CMD_RESET);
    inhibit("ff");
    device(1'b0, 0, bits);
    wait_done();
    check("ff_frame", bits, 10'h3FF);
    check("ff_done", done_seen, 1);
    check("ff_err", err_seen, 1);

    // device never clocks
    accept(CMD_SET_LED);
    inhibit("tmo");
    n = 0;
    for (int i = 0; i < TMO + 50; i++) begin
      tick();
      n++;
      if (done_seen) break;
    end
    check("tmo_len", n, TMO);
    check("tmo_err", err_seen, 1);
    check("tmo_clkdrv", ps2clk_drv, 0);
    check("tmo_datdrv", ps2dat_drv, 0);
    check("tmo_ready", tx_ready, 1);

    // reset at fall 5 (bit4 of 0xED is 0)
    accept(CMD_SET_LED);
    inhibit("rst");
    device(1'b1, 5, bits);
    repeat (4) tick();
    check("rst_pre_dat", ps2dat_drv, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_clk", ps2clk_drv, 0);
    check("rst_mid_dat", ps2dat_drv, 0);
    dev_clk_lo = 1'b0;
    dev_dat_lo = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("rst_after_rdy", tx_ready, 1);
    check("rst_after_busy", tx_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
